// File: rtl/uart_tx_fifo.sv
// Byte FIFO that buffers uart_rx output and launches uart_tx one byte per frame.
// The read scheduler waits for a full busy/idle cycle of tx_rdy before it pops again.
module uart_tx_fifo #(
  parameter int  DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              ovf_clr,
  input  logic              tx_rdy,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_e;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, full_q;
  logic              overflow_q, overflow_d;
  logic              txEn_q;
  logic [7:0]        txData_q, txData_d;
  logic              push, pop;

  // A full FIFO still accepts a write when the scheduler frees a slot that same cycle.
  always_comb begin
    pop        = (state_q == IDLE) && !empty_q && tx_rdy;
    push       = wr_en && (!full_q || pop);
    wrPtr_d    = push ? wrPtr_q + ADDR_W'(1) : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + ADDR_W'(1) : rdPtr_q;
    txData_d   = pop  ? mem_q[rdPtr_q] : txData_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (wr_en && full_q && !pop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_rdy) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_rdy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      txEn_q     <= 1'b0;
      txData_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == FULL_COUNT);
      overflow_q <= overflow_d;
      txEn_q     <= (state_d == LAUNCH);
      txData_q   <= txData_d;
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= wr_data;
    end
  end

  assign tx_en    = txEn_q;
  assign tx_data  = txData_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo with a queue-based reference model and a
// behavioural uart_tx that holds rdy low for frameLen cycles after each launch.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic       tx_rdy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] modelQ[$];
  bit         mOvf, mTxEn;
  logic [7:0] mTxData;
  bit         gateOpen, needLow, needHigh;

  int         uartBusy  = 0;
  int         frameLen  = 20;
  int         rdyMode   = 0;
  int         cycleNo   = 0;
  int         lastPulse = -1;
  bit         spacingOn = 0;
  int         peakCount = 0;
  logic [7:0] lastEmitted = 8'h00;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .tx_rdy   (tx_rdy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #700000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    mOvf     = 0;
    mTxEn    = 0;
    mTxData  = 8'h00;
    gateOpen = 1;
    needLow  = 0;
    needHigh = 0;
    uartBusy = 0;
  endtask

  // One clock of the reference: the byte stream is a queue, and a new launch is
  // allowed only once rdy has been seen low and then high after the previous launch.
  task automatic modelStep(input bit we, input logic [7:0] wd, input bit clr, input bit rdy);
    bit         doPop, wasFull, setOvf;
    logic [7:0] nextData;
    doPop    = gateOpen && (modelQ.size() > 0) && rdy;
    wasFull  = (modelQ.size() == DEPTH);
    setOvf   = 0;
    nextData = mTxData;
    if (doPop) nextData = modelQ.pop_front();
    if (we) begin
      if (!wasFull || doPop) modelQ.push_back(wd);
      else setOvf = 1;
    end
    mOvf = setOvf ? 1'b1 : (clr ? 1'b0 : mOvf);
    if (mTxEn) needLow = 1;
    else if (needLow && !rdy) begin
      needLow  = 0;
      needHigh = 1;
    end else if (needHigh && rdy) begin
      needHigh = 0;
      gateOpen = 1;
    end
    if (doPop) gateOpen = 0;
    mTxEn   = doPop;
    mTxData = nextData;
  endtask

  task automatic checkAll();
    checkOutput("count",    32'(count),    32'(modelQ.size()));
    checkOutput("empty",    32'(empty),    32'(modelQ.size() == 0));
    checkOutput("full",     32'(full),     32'(modelQ.size() == DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
    checkOutput("tx_en",    32'(tx_en),    32'(mTxEn));
    checkOutput("tx_data",  32'(tx_data),  32'(mTxData));
    if (tx_en === 1'b1) begin
      lastEmitted = tx_data;
      if (spacingOn && lastPulse >= 0)
        checkOutput("txSpacing", 32'((cycleNo - lastPulse) >= 102), 32'd1);
      lastPulse = cycleNo;
    end
    if (int'(count) > peakCount) peakCount = int'(count);
  endtask

  task automatic applyStimulus(input bit we, input logic [7:0] wd, input bit clr, input bit rdy);
    wr_en   = we;
    wr_data = wd;
    ovf_clr = clr;
    tx_rdy  = rdy;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic stepCycle(input bit we, input logic [7:0] wd, input bit clr);
    bit rdyNow;
    checkAll();
    rdyNow = (rdyMode == 1) ? 1'b0 : (uartBusy == 0);
    if (uartBusy > 0) uartBusy--;
    if (mTxEn) uartBusy = frameLen;
    applyStimulus(we, wd, clr, rdyNow);
    modelStep(we, wd, clr, rdyNow);
    @(negedge clk);
    cycleNo++;
  endtask

  task automatic drain(input int maxCycles);
    int n = 0;
    while ((modelQ.size() > 0 || !gateOpen) && n < maxCycles) begin
      stepCycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (modelQ.size() > 0 || !gateOpen) checkOutput("drainTimeout", 32'd0, 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Count"},  32'(count),    32'd0);
    checkOutput({tag, "Empty"},  32'(empty),    32'd1);
    checkOutput({tag, "Full"},   32'(full),     32'd0);
    checkOutput({tag, "Ovf"},    32'(overflow), 32'd0);
    checkOutput({tag, "TxEn"},   32'(tx_en),    32'd0);
    checkOutput({tag, "TxData"}, 32'(tx_data),  32'h00);
  endtask

  task automatic resetMidCycle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    #1 checkResetValues("asyncReset");
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    $display("[TB] single write");
    frameLen = 20;
    for (int i = 0; i < 8; i++) stepCycle(1'b0, 8'h00, 1'b0);
    stepCycle(1'b1, 8'hA5, 1'b0);
    checkOutput("singleCountN1", 32'(count), 32'd1);
    stepCycle(1'b0, 8'h00, 1'b0);
    checkOutput("singleTxEn", 32'(tx_en), 32'd1);
    checkOutput("singleTxData", 32'(tx_data), 32'hA5);
    checkOutput("singleCountN2", 32'(count), 32'd0);
    drain(200);

    $display("[TB] burst of five");
    frameLen  = 100;
    spacingOn = 1;
    lastPulse = -1;
    peakCount = 0;
    for (int i = 1; i <= 5; i++) stepCycle(1'b1, 8'(i), 1'b0);
    drain(1000);
    checkOutput("burstPeak", 32'(peakCount), 32'd4);
    checkOutput("burstLast", 32'(lastEmitted), 32'h05);
    spacingOn = 0;

    $display("[TB] overflow with rdy held low");
    frameLen = 10;
    rdyMode  = 1;
    for (int i = 0; i < DEPTH; i++) stepCycle(1'b1, 8'(8'h30 + i), 1'b0);
    checkOutput("fullAfter16", 32'(full), 32'd1);
    stepCycle(1'b1, 8'hFF, 1'b0);
    checkOutput("ovfAfter17", 32'(overflow), 32'd1);
    checkOutput("countAfter17", 32'(count), 32'd16);
    stepCycle(1'b0, 8'h00, 1'b1);
    checkOutput("ovfCleared", 32'(overflow), 32'd0);
    rdyMode = 0;
    drain(1000);
    checkOutput("ovfDrainLast", 32'(lastEmitted), 32'h3F);

    $display("[TB] write while full and popping");
    rdyMode = 1;
    for (int i = 0; i < DEPTH; i++) stepCycle(1'b1, 8'(8'h50 + i), 1'b0);
    rdyMode = 0;
    stepCycle(1'b1, 8'hEE, 1'b0);
    checkOutput("fullPopCount", 32'(count), 32'd16);
    checkOutput("fullPopOvf", 32'(overflow), 32'd0);
    drain(1000);
    checkOutput("fullPopLast", 32'(lastEmitted), 32'hEE);

    $display("[TB] forty bytes across pointer wrap");
    frameLen = 3;
    begin
      int sent = 0;
      int guard = 0;
      while (sent < 40 && guard < 2000) begin
        if ($urandom_range(0, 99) < 60 && modelQ.size() < DEPTH) begin
          stepCycle(1'b1, 8'($urandom), 1'b0);
          sent++;
        end else begin
          stepCycle(1'b0, 8'h00, 1'b0);
        end
        guard++;
      end
      checkOutput("wrapSent", 32'(sent), 32'd40);
    end
    drain(1000);

    $display("[TB] random traffic");
    for (int blk = 0; blk < 12; blk++) begin
      frameLen = $urandom_range(1, 20);
      rdyMode  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      for (int i = 0; i < 200; i++)
        stepCycle($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 29) == 0);
    end
    rdyMode = 0;
    drain(2000);

    $display("[TB] reset during frame");
    frameLen = 50;
    for (int i = 0; i < 4; i++) stepCycle(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 15; i++) stepCycle(1'b0, 8'h00, 1'b0);
    checkOutput("storedBeforeReset", 32'(count), 32'd3);
    resetMidCycle();
    for (int i = 0; i < 20; i++) stepCycle(1'b0, 8'h00, 1'b0);
    stepCycle(1'b1, 8'h77, 1'b0);
    drain(200);
    checkOutput("afterResetLast", 32'(lastEmitted), 32'h77);
    stepCycle(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO with transmit scheduler. Sits between the uart_rx byte output and the uart_tx input in the loopback and echo paths.
- Absorbs receive bursts and feeds uart_tx one byte per completed frame, so no byte is lost while the transmitter is busy.
- Write side takes the uart_rx single-cycle data_ready pulse directly. Read side drives the uart_tx en/data_in pair and watches its rdy.

Parameters:
- DEPTH, 16, number of byte entries; power of two, 2..256.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  one-cycle write strobe; connects to uart_rx data_ready.
- wr_data  in  8  byte to enqueue; sampled when wr_en=1.
- ovf_clr  in  1  clears overflow.
- tx_rdy  in  1  uart_tx rdy; 1 = idle and able to accept a byte.
- tx_en  out  1  one-cycle launch pulse to uart_tx en.
- tx_data  out  8  byte to uart_tx data_in; stable from tx_en until the frame completes.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; a write was dropped.

Behaviour:
Reset (rst_n=0, asynchronous):
- Pointers=0, count=0, empty=1, full=0, overflow=0, tx_en=0, tx_data=8'h00, FSM=IDLE.
- Reset asserted mid-frame discards all stored bytes and the byte in flight. The FIFO does not retransmit.

Storage:
- DEPTH x 8 array; wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH.
- count is the registered occupancy. empty, full and count are registered outputs consistent in the same cycle.

Write:
- wr_en=1 and not full: store wr_data at wr_ptr, wr_ptr+1, count+1 on the next edge.
- wr_en=1 and full with no pop in that cycle: byte dropped, pointers and count unchanged, overflow<=1.
- wr_en=1 and full with a pop in that cycle: write accepted, count unchanged.
- Write and pop in the same cycle, any fill level: count unchanged.

Overflow:
- Cleared by ovf_clr=1.
- If a set event and ovf_clr occur in the same cycle, set wins.

Read FSM (states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE):
- IDLE: if count!=0 and tx_rdy=1, then tx_data<=mem[rd_ptr], rd_ptr+1, count-1, go to LAUNCH. Otherwise stay.
- LAUNCH: tx_en=1 for exactly this one cycle. Go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_rdy=0, then go to WAIT_DONE. No timeout.
- WAIT_DONE: wait for tx_rdy=1, then go to IDLE.
- tx_en is registered and equals (state==LAUNCH); it is never high on two consecutive cycles.
- tx_data changes only on the IDLE->LAUNCH edge.

Latency and throughput:
- A write at cycle N into an empty FIFO with tx_rdy=1 gives count=1 at N+1 and tx_en=1 at N+2.
- Minimum spacing between tx_en pulses is one full frame plus 2 cycles (WAIT_DONE->IDLE->LAUNCH).
- A byte written while the FSM is outside IDLE waits; pop happens on the first IDLE cycle with tx_rdy=1.

Boundaries:
- Pointer wrap at DEPTH-1 -> 0 must preserve FIFO order.
- Empty FIFO: the FSM never leaves IDLE and tx_en stays 0.
- Full FIFO with tx_rdy held 0: no pops occur and every further write sets overflow.

Test Plan:
1. Reset then single write 8'hA5 at cycle 10, tx_rdy=1 -> count=1 at 11, tx_en pulse at 12 with tx_data=8'hA5, count=0 at 12. tx_en stays low until tx_rdy toggles 0->1.
2. Burst of 5 back-to-back writes 8'h01..8'h05 with a behavioural uart_tx model (rdy low for 100 cycles after en) -> five tx_en pulses, data 01,02,03,04,05 in order, each at least 102 cycles apart. count peaks at 4.
3. tx_rdy held 0, DEPTH=16, write 17 bytes -> full=1 after 16, 17th dropped, overflow=1. ovf_clr pulse -> overflow=0. Release tx_rdy -> 16 bytes emitted in order.
4. Fill to full, then write 8'hEE in the same cycle the FSM pops -> write accepted, count stays 16, overflow stays 0. 8'hEE emitted last.
5. Push 40 bytes through DEPTH=16 with continuous drain -> output order matches input across pointer wrap, and count never exceeds 16.
6. Assert rst_n=0 while in WAIT_DONE with 3 bytes stored -> immediately count=0, empty=1, tx_en=0, tx_data=8'h00, FSM=IDLE. No tx_en after release until a new write.
